instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Front-end fetch stage of the 5-stage MIPS pipeline. Owns the program counter, issues word requests to instruction memory over a req/ack handshake with variable latency, and presents a registered (PC+4, instruction, valid) triple that the IF/ID pipeline register samples every clock. Handles hazard-unit stalls through a one-entry skid buffer and branch/jump redirects, which squash in-flight fetches.

## Interface
- RESET_PC, 32'h0040_0000, address of the first fetch after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- stall_i  in  1  hazard unit: downstream cannot accept a new instruction; outputs must hold.
- redirect_i  in  1  single-cycle pulse: taken branch/jump, flush and refetch.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word address; stable while imem_req_o=1 and ack not yet seen.
- imem_ack_i  in  1  memory response; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  instruction word.
- out_PC_4  out  32  address of the presented instruction +4.
- out_Instruction  out  32  fetched instruction; 32'h0 (sll $0 NOP) when out_valid=0.
- out_valid  out  1  out_Instruction is real.

## Operation
- Registers: req_pc (outstanding address), redirect_pc (pending target), skid {valid, instr, pc4}, outputs, 2-bit FSM.
- States: FETCH (imem_req_o=1), HOLD (skid full, imem_req_o=0), FLUSH (imem_req_o=1, response to be discarded).
- imem_addr_o = req_pc in every state.
- Handshake: once raised, a request stays raised with constant address until ack; it is never withdrawn except by reset. Ack in the same cycle as req is legal.
- FETCH, ack, no redirect:
  - stall_i=0 and skid empty: outputs <= {req_pc+4, rdata, 1}; req_pc <= req_pc+4; stay.
  - stall_i=1: skid <= {req_pc+4, rdata}; req_pc <= req_pc+4; go HOLD.
- FETCH, no ack, stall_i=0: outputs <= {unchanged out_PC_4, 0, 0} (bubble).
- Any state with stall_i=1: out_* hold their values.
- HOLD, stall_i=0: outputs <= skid; skid cleared; go FETCH.
- Redirect (highest priority, overrides stall_i):
  - skid cleared; outputs <= bubble.
  - FETCH with ack, or HOLD: req_pc <= target; go/stay FETCH.
  - FETCH without ack: redirect_pc <= target; go FLUSH.
- FLUSH: on ack, rdata is dropped and req_pc <= redirect_pc; go FETCH. A second redirect while in FLUSH overwrites redirect_pc.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: req_pc=RESET_PC, state=FETCH, skid empty, out_PC_4=0, out_Instruction=0, out_valid=0. imem_req_o=1 in the first cycle after reset release.
- Latency: request accepted at edge N gives outputs valid after edge N. With zero-wait memory (ack=req), one instruction per cycle.
- Stall: assertion takes effect at the same edge; outputs unchanged while asserted. After release, the skid instruction appears at the next edge and a new request issues in that cycle.
- Redirect: bubble on outputs at the next edge. The first target instruction appears no earlier than 1 cycle later (zero-wait) and no earlier than the ack of the squashed request plus 1 cycle (FLUSH).
- Reset mid-transaction: immediate return to reset values; the pending memory response is lost. Memory must tolerate request abandonment on reset.

## Test plan
- Reset release, zero-wait memory returning addr as data: out_valid=1 with out_PC_4=32'h0040_0004, 0040_0008, … each cycle; req_pc advances by 4.
- 3-cycle ack latency: out_valid pulses every 4th cycle; bubbles show out_Instruction=0; imem_addr_o stable while waiting.
- stall_i held 3 cycles with zero-wait memory: outputs frozen; exactly one extra fetch into skid, then imem_req_o=0. After release, the skid instruction appears, then sequential fetch resumes with no loss or duplicate.
- Redirect to 32'h0040_0103 during 2-cycle-latency fetch: next output is a bubble; the old response is discarded; the next request is addressed 32'h0040_0100.
- Redirect coincident with stall_i=1 and full skid: skid flushed; the next delivered instruction is from the target.
- PC at 32'hFFFF_FFFC: out_PC_4=0, next request address 0. Reset asserted mid-wait: all outputs 0 asynchronously and refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and imem req/ack front end with a one-entry skid buffer,
// stall holding and redirect squashing of in-flight fetches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] out_PC_4,
    output logic [31:0] out_Instruction,
    output logic        out_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;

    state_t      state, state_n;
    logic [31:0] req_pc, req_pc_n, redirect_pc, redirect_pc_n;
    logic [31:0] skid_instr, skid_instr_n, skid_pc4, skid_pc4_n;
    logic        skid_valid, skid_valid_n;
    logic [31:0] pc4_n, instr_n;
    logic        valid_n;
    logic [31:0] target, next_pc;
    logic        ack;

    assign imem_req_o  = state != HOLD;
    assign imem_addr_o = req_pc;
    assign target      = redirect_pc_i & ~32'd3;
    assign next_pc     = req_pc + 32'd4;
    assign ack         = imem_ack_i && imem_req_o;

    always_comb begin
        state_n       = state;
        req_pc_n      = req_pc;
        redirect_pc_n = redirect_pc;
        skid_valid_n  = skid_valid;
        skid_instr_n  = skid_instr;
        skid_pc4_n    = skid_pc4;
        pc4_n         = out_PC_4;
        instr_n       = out_Instruction;
        valid_n       = out_valid;
        if (redirect_i) begin
            skid_valid_n = 1'b0;
            instr_n      = 32'h0;
            valid_n      = 1'b0;
            // a request still waiting for ack must complete before the target is issued
            if (state != HOLD && !ack) begin
                redirect_pc_n = target;
                state_n       = FLUSH;
            end else begin
                req_pc_n = target;
                state_n  = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        req_pc_n = next_pc;
                        if (stall_i) begin
                            skid_valid_n = 1'b1;
                            skid_instr_n = imem_rdata_i;
                            skid_pc4_n   = next_pc;
                            state_n      = HOLD;
                        end else begin
                            pc4_n   = next_pc;
                            instr_n = imem_rdata_i;
                            valid_n = 1'b1;
                        end
                    end else if (!stall_i) begin
                        instr_n = 32'h0;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        pc4_n        = skid_pc4;
                        instr_n      = skid_instr;
                        valid_n      = skid_valid;
                        skid_valid_n = 1'b0;
                        state_n      = FETCH;
                    end
                end
                FLUSH: begin
                    if (ack) begin
                        req_pc_n = redirect_pc;
                        state_n  = FETCH;
                    end
                    if (!stall_i) begin
                        instr_n = 32'h0;
                        valid_n = 1'b0;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= FETCH;
            req_pc          <= RESET_PC;
            redirect_pc     <= 32'h0;
            skid_valid      <= 1'b0;
            skid_instr      <= 32'h0;
            skid_pc4        <= 32'h0;
            out_PC_4        <= 32'h0;
            out_Instruction <= 32'h0;
            out_valid       <= 1'b0;
        end else begin
            state           <= state_n;
            req_pc          <= req_pc_n;
            redirect_pc     <= redirect_pc_n;
            skid_valid      <= skid_valid_n;
            skid_instr      <= skid_instr_n;
            skid_pc4        <= skid_pc4_n;
            out_PC_4        <= pc4_n;
            out_Instruction <= instr_n;
            out_valid       <= valid_n;
        end
    end
endmodule
